regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Arbiter for the single write port of the MIPS register file. The file is built from D-storage cells with one write enable. Two requesters share the port: A is ALU/writeback and B is load return. The block grants them round-robin, issues at most one registered write per cycle, and returns a one-cycle acknowledge to the winner. It sits between the writeback stage and the register bank's write-enable/address/data inputs.

## Interface
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_a  input  1  requester A has a write pending
- addr_a  input  ADDR_W  destination register for A
- data_a  input  DATA_W  write data for A
- req_b  input  1  requester B has a write pending
- addr_b  input  ADDR_W  destination register for B
- data_b  input  DATA_W  write data for B
- freeze  input  1  pipeline stall; blocks all grants while high
- ack_a  output  1  one-cycle pulse, A's transaction consumed
- ack_b  output  1  one-cycle pulse, B's transaction consumed
- we  output  1  register bank write enable
- waddr  output  ADDR_W  register bank write address
- wdata  output  DATA_W  register bank write data

## Operation
- FSM states: IDLE (no grant last edge), WR_A (A granted last edge), WR_B (B granted last edge).
- Eligibility at each edge:
  - A is eligible if req_a=1 and state != WR_A.
  - B is eligible if req_b=1 and state != WR_B.
  - This lockout means a requester is never granted on two consecutive edges. It prevents double-consuming a held req.
- Selection:
  - Only one eligible: grant it.
  - Both eligible: grant the one not granted most recently. The `last` pointer is updated on every grant and reset to B, so A wins the first tie.
- Grant to X: next state is WR_X, ack_x=1, waddr=addr_x, wdata=data_x.
  - we=1 unless addr_x==0. A write to $zero is acknowledged with we=0.
- No eligible requester, or freeze=1: next state IDLE, we=0, ack_a=ack_b=0.
  - waddr/wdata hold their previous values.
  - `last` is unchanged.
- Freeze also clears the lockout. The state becomes IDLE, so the first grant after freeze may go to the last-granted requester.
- Same destination address from A and B: they are written on successive edges in grant order. The later write wins.
- Requester contract: req/addr/data are held stable until ack is seen. At the edge ending the ack cycle, the requester deasserts req or presents the next transaction.
- The bank is written by the downstream cells; this block only drives enables and holds no register contents.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, last=B
  - ack_a=ack_b=0, we=0
  - waddr=0, wdata=0
- Outputs are all registered; nothing is combinational from inputs to outputs.
- Latency: req sampled high at edge N gives ack/we/waddr/wdata valid during cycle N..N+1, i.e. one cycle after req is presented.
- ack_x and we are single-cycle pulses per grant.
- Throughput:
  - Aggregate: 1 write/cycle when A and B alternate.
  - Single requester: 1 write per 2 cycles.
- Simultaneous freeze and requests: freeze dominates and nothing is granted. Pending reqs are granted on the first edge with freeze=0.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) and the in-flight ack is lost. The requester re-presents after reset.
- Deassertion of rst_n is assumed synchronized upstream. The first grant can occur at the first edge with rst_n=1.

## Test plan
- Reset check: rst_n=0 with req_a=req_b=1 → ack_a=ack_b=we=0, waddr=0, wdata=0. After release, the first grant goes to A.
- Tie round-robin: req_a (addr 3, data 0x11) and req_b (addr 4, data 0x22) held high, each dropped at the end of its ack.
  - Cycle 1: A written (we=1, waddr=3).
  - Cycle 2: B written (waddr=4).
  - Then idle, we=0.
- Single-requester lockout: req_a held high for 6 cycles with the same addr 7 and the requester not updating → ack_a and we pulse on alternating cycles, never on consecutive cycles.
- $zero write: req_b with addr_b=0, data 0xDEADBEEF → ack_b=1, we=0, waddr=0.
- Freeze: freeze=1 for 3 cycles with req_a=1 → no ack, we=0 throughout. ack_a occurs one cycle after freeze drops.
- Same-address race: A and B both target addr 9 (A data 0xAAAA, B data 0xBBBB), tie with last=B → write sequence 0xAAAA then 0xBBBB, so the final value is 0xBBBB.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the single register-file write port.
// Requester A (ALU/writeback) and B (load return); one registered write per cycle.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              freeze,
  output logic              ack_a,
  output logic              ack_b,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_b_q;
  logic   elig_a, elig_b;
  logic   gnt_a, gnt_b;

  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (gnt_a || gnt_b)
        last_b_q <= gnt_b;
    end
  end

  // Lockout on the last grant stops a held req being consumed twice.
  always_comb begin
    elig_a  = req_a && (state_q != WR_A) && !freeze;
    elig_b  = req_b && (state_q != WR_B) && !freeze;
    gnt_a   = elig_a && (!elig_b || last_b_q);
    gnt_b   = elig_b && !gnt_a;
    state_d = IDLE;
    unique case (1'b1)
      gnt_a:   state_d = WR_A;
      gnt_b:   state_d = WR_B;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_a;
    data_d = data_a;
    if (gnt_b) begin
      addr_d = addr_b;
      data_d = data_b;
    end
    we_d = (gnt_a || gnt_b) && (addr_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      ack_a <= gnt_a;
      ack_b <= gnt_b;
      we    <= we_d;
      if (gnt_a || gnt_b) begin
        waddr <= addr_d;
        wdata <= data_d;
      end
    end
  end

endmodule
